// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the 32-byte memory arbiter. Rev 1.0.
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way grant picker, round-robin unless MEM_ARB_FIXED_PRIO_EN. Rev 1.0.
`default_nettype none

module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic rr_last,
`endif
  input  logic req1,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = REQ0;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_id = REQ0;
`else
      // On a tie the requester that did not win last time goes first.
      grant_id = ~rr_last;
`endif
    end else if (req1) begin
      grant_id = REQ1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem32_arbiter.sv
// mem32_arbiter: two-requester controller for the shared 32-byte memory (IDLE->ACCESS->DONE).
// Rev 1.0. Build option MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
`default_nettype none

module mem32_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic              winner_q, winner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_valid;
  logic              grant_id;
  logic              win_we;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic rr_last_q, rr_last_d;
`endif

  rr_pick2 u_pick (
    .req0        (req0),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .rr_last     (rr_last_q),
`endif
    .req1        (req1),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign win_we = (grant_id == REQ1) ? we1 : we0;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d     = ACCESS;
          winner_d    = grant_id;
          mem_addr_d  = (grant_id == REQ1) ? addr1  : addr0;
          mem_wdata_d = (grant_id == REQ1) ? wdata1 : wdata0;
          mem_write_d = win_we;
          mem_read_d  = ~win_we;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_last_d   = grant_id;
`endif
        end
      end
      ACCESS: begin
        // Read data is only valid while our read strobe is up.
        if (mem_read_q) rdata_d = mem_rdata;
        done0_d = (winner_q == REQ0);
        done1_d = (winner_q == REQ1);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      winner_q    <= REQ0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_last_q   <= REQ1;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata_q     <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem32_arbiter.sv
// tb_mem32_arbiter: directed and random checks of mem32_arbiter against a transaction-level model.
`default_nettype none

module tb_mem32_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] we;
  logic [4:0] addr  [2];
  logic [7:0] wdata [2];
  logic       done0, done1, busy, mem_read, mem_write;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;

  always #5 clk = ~clk;

  mem32_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .done0(done0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .done1(done1),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // The shared memory device itself
  logic       mem_init;
  logic [7:0] sim_mem [32];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) sim_mem[i] <= 8'((i * 37 + 11) & 8'hFF);
    end else if (mem_write) begin
      sim_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? sim_mem[mem_addr] : 'z;

  // Transaction-level reference: at most one access in flight, described by who/what and
  // how many cycles of it remain (strobe cycle, then done cycle).
  logic [7:0] ref_mem [32];
  int         left;
  logic       cur_id, cur_we, last_win;
  logic [4:0] cur_addr;
  logic [7:0] cur_data, ref_rdata;

  int   n_vec = 0;
  int   n_bad = 0;
  int   issued = 0;
  bit   rnd_en = 0;
  bit   rec = 0;
  logic [1:0] auto_rearm = 2'b00;
  logic [1:0] rearm = 2'b00;
  int   grants[$];
  int   strobes_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    left      = 0;
    last_win  = 1'b1;
    ref_rdata = 8'h00;
  endtask

  task automatic model_edge();
    logic w;
    if (left > 0) begin
      if (left == 2) begin
        if (cur_we) ref_mem[cur_addr] = cur_data;
        else        ref_rdata = ref_mem[cur_addr];
      end
      left--;
    end else if (req != 2'b00) begin
      if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = ~last_win;
`endif
      end else begin
        w = req[1];
      end
      cur_id   = w;
      cur_we   = we[w];
      cur_addr = addr[w];
      cur_data = wdata[w];
      last_win = w;
      left     = 2;
    end
  endtask

  task automatic check_outputs();
    chk("busy",      32'(busy),      32'(left > 0));
    chk("mem_write", 32'(mem_write), 32'(left == 2 && cur_we));
    chk("mem_read",  32'(mem_read),  32'(left == 2 && !cur_we));
    chk("done0",     32'(done0),     32'(left == 1 && cur_id == 1'b0));
    chk("done1",     32'(done1),     32'(left == 1 && cur_id == 1'b1));
    chk("rdata",     32'(rdata),     32'(ref_rdata));
    chk("excl",      32'(mem_read & mem_write), 32'd0);
    if (left == 2) begin
      chk("mem_addr", 32'(mem_addr), 32'(cur_addr));
      if (cur_we) chk("mem_wdata", 32'(mem_wdata), 32'(cur_data));
    end
    if (mem_write) strobes_seen++;
    if (rec && done0) grants.push_back(0);
    if (rec && done1) grants.push_back(1);
  endtask

  task automatic issue(input int k, input logic w, input logic [4:0] a, input logic [7:0] d);
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  task automatic drive();
    logic [1:0] dn;
    dn = {done1, done0};
    for (int k = 0; k < 2; k++) begin
      if (req[k] && dn[k]) begin
        req[k]   = 1'b0;
        rearm[k] = auto_rearm[k];
      end else if (!req[k]) begin
        if (rearm[k]) begin
          req[k]   = 1'b1;
          rearm[k] = 1'b0;
        end else if (rnd_en && $urandom_range(0, 3) == 0) begin
          issue(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
          issued++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    drive();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((req != 2'b00 || left > 0 || rearm != 2'b00) && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) chk("drain_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    logic [7:0] keep;
    reset    = 1'b0;
    mem_init = 1'b1;
    req      = 2'b00;
    we       = 2'b00;
    addr[0]  = '0; addr[1]  = '0;
    wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'((i * 37 + 11) & 8'hFF);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_read",  32'(mem_read),  32'd0);
    chk("rst_done",  32'({done1, done0}), 32'd0);
    chk("rst_rdata", 32'(rdata),     32'd0);
    chk("rst_addr",  32'(mem_addr),  32'd0);
    reset = 1'b1;
    cycle();

    // Single write then read from requester 0
    strobes_seen = 0;
    issue(0, 1'b1, 5'd19, 8'hA5);
    drain(20);
    chk("wr_strobe_cycles", 32'(strobes_seen), 32'd1);
    issue(0, 1'b0, 5'd19, 8'h00);
    drain(20);
    chk("rd_rdata_A5", 32'(rdata), 32'hA5);

    // Hold-off: requester 1 arrives while requester 0 is being served
    keep = rdata;
    issue(0, 1'b1, 5'd3, 8'h11);
    cycle();
    issue(1, 1'b1, 5'd4, 8'h3C);
    drain(20);
    chk("holdoff_rdata", 32'(rdata), 32'(keep));
    chk("holdoff_mem4",  32'(sim_mem[4]), 32'h3C);

    // Contention: both requesters re-raise right after each done
    auto_rearm = 2'b11;
    rec = 1'b1;
    issue(0, 1'b1, 5'd10, 8'h01);
    issue(1, 1'b0, 5'd10, 8'h00);
    repeat (12) cycle();
    rec = 1'b0;
    auto_rearm = 2'b00;
    rearm = 2'b00;
    drain(30);
    chk("cont_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("cont_grant", 32'(grants[i]), 32'd0);
`else
      chk("cont_grant", 32'(grants[i]), 32'(i % 2));
`endif
    end

    // Random traffic
    rnd_en = 1'b1;
    for (int n = 0; n < 4000 && issued < 200; n++) cycle();
    rnd_en = 1'b0;
    chk("rand_issued", 32'(issued >= 200), 32'd1);
    drain(40);

    // Reset in the middle of a write access
    issue(0, 1'b1, 5'd7, 8'h5A);
    keep = sim_mem[7];
    cycle();
    chk("pre_rst_write", 32'(mem_write), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_write", 32'(mem_write), 32'd0);
    chk("arst_done0", 32'(done0),     32'd0);
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_rdata", 32'(rdata),     32'd0);
    @(posedge clk);
    #1;
    chk("arst_nowrite", 32'(sim_mem[7]), 32'(keep));
    chk("arst_done0b",  32'(done0),      32'd0);
    @(negedge clk);
    req   = 2'b00;
    reset = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
